// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch FSM states and instruction-register command encodings
package fetch_pkg;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} fetch_state_t;
    localparam logic [1:0] IR_HOLD  = 2'b00;
    localparam logic [1:0] IR_LOAD  = 2'b01;
    localparam logic [1:0] IR_CLEAR = 2'b10;
endpackage

// File: rtl/fetch_timeout_ctr.sv
// fetch_timeout_ctr: counts idle response cycles and flags the last allowed one
module fetch_timeout_ctr #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;
    logic [W-1:0] count;
    // clear wins over counting so a fresh wait always starts from zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count <= '0;
        else if (clear) count <= '0;
        else if (enable) count <= count + W'(1);
    end
    // expiry is flagged on the cycle whose increment would reach LIMIT
    assign expired = enable && !clear && (count == W'(LIMIT - 1));
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetch FSM (optional INSTR_MISALIGN_CHECK_EN)
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic [31:0] fetch_addr,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  ir_control,
    output logic [31:0] instr_data,
    output logic        fetch_busy,
    output logic        fetch_done,
    output logic        fetch_err
);
    fetch_state_t state;
    logic waiting;
    logic timeout;
    assign waiting = (state == WAIT) || (state == DRAIN);
    fetch_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (!waiting || (state == WAIT && flush)),
        .enable (waiting && !mem_rvalid),
        .expired(timeout)
    );
    // fetch sequencing; every output is a flop updated alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            instr_data <= '0;
            ir_control <= IR_HOLD;
            fetch_busy <= 1'b0;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            ir_control <= IR_HOLD;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) ir_control <= IR_CLEAR;
                    else if (fetch_start) begin
`ifdef INSTR_MISALIGN_CHECK_EN
                        if (fetch_addr[1:0] != 2'b00) begin
                            fetch_err  <= 1'b1;
                            ir_control <= IR_CLEAR;
                        end else
`endif
                        begin
                            mem_addr   <= fetch_addr & ~32'h3;
                            mem_req    <= 1'b1;
                            fetch_busy <= 1'b1;
                            state      <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (flush) begin
                        ir_control <= IR_CLEAR;
                        mem_req    <= 1'b0;
                        fetch_busy <= mem_gnt;
                        state      <= mem_gnt ? DRAIN : IDLE;
                    end else if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        ir_control <= IR_CLEAR;
                        fetch_busy <= !mem_rvalid;
                        state      <= mem_rvalid ? IDLE : DRAIN;
                    end else if (mem_rvalid) begin
                        instr_data <= mem_rdata;
                        ir_control <= IR_LOAD;
                        fetch_done <= 1'b1;
                        state      <= DONE;
                    end else if (timeout) begin
                        fetch_err  <= 1'b1;
                        ir_control <= IR_CLEAR;
                        fetch_busy <= 1'b0;
                        state      <= IDLE;
                    end
                end
                DONE: begin
                    if (flush) ir_control <= IR_CLEAR;
                    fetch_busy <= 1'b0;
                    state      <= IDLE;
                end
                DRAIN: begin
                    if (flush || timeout) ir_control <= IR_CLEAR;
                    fetch_err <= timeout;
                    if (mem_rvalid || timeout) begin
                        fetch_busy <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    mem_req    <= 1'b0;
                    fetch_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, max cycles waiting for mem_rvalid before error.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 fetch_start  input  1  control-unit request to fetch at fetch_addr; sampled only in IDLE.
REQ-005 fetch_addr  input  32  byte address of instruction.
REQ-006 flush  input  1  abort any fetch in progress and clear the instruction register.
REQ-007 mem_req  output  1  read request to instruction memory.
REQ-008 mem_addr  output  32  request address, stable while mem_req=1.
REQ-009 mem_gnt  input  1  memory accepts request in the cycle mem_req=1 and mem_gnt=1.
REQ-010 mem_rvalid  input  1  read data valid, one cycle per accepted request.
REQ-011 mem_rdata  input  32  read data.
REQ-012 ir_control  output  2  {clear, load} command to the instruction register; 00 hold, 01 load, 10 clear.
REQ-013 instr_data  output  32  instruction word presented to the instruction register.
REQ-014 fetch_busy  output  1  high in every state except IDLE.
REQ-015 fetch_done  output  1  one-cycle pulse coincident with ir_control=01.
REQ-016 fetch_err  output  1  one-cycle error pulse (timeout or misalignment).

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, DONE, DRAIN; all outputs registered.
REQ-018 IDLE: fetch_start=1 latches fetch_addr into mem_addr, next state REQ; fetch_start outside IDLE ignored.
REQ-019 REQ: mem_req=1 held with constant mem_addr until mem_gnt=1, then mem_req drops and next state WAIT.
REQ-020 WAIT: mem_rvalid=1 latches mem_rdata into instr_data, next state DONE; mem_rvalid in IDLE/REQ/DONE ignored.
REQ-021 DONE (one cycle): ir_control=01, fetch_done=1, instr_data valid; next state IDLE.
REQ-022 Minimum latency: fetch_start cycle N, mem_req cycle N+1, gnt N+1, rvalid N+2, fetch_done N+3.
REQ-023 Timeout: 8-bit-or-wider counter clears on WAIT/DRAIN entry, increments each cycle there without mem_rvalid; reaching TIMEOUT_CYCLES gives fetch_err pulse, ir_control=10, next state IDLE.
REQ-024 flush has priority over all other events; ir_control=10 for exactly one cycle following any flush.
REQ-025 flush in REQ without mem_gnt: mem_req drops next cycle, next state IDLE, no response expected.
REQ-026 flush in REQ with simultaneous mem_gnt, or in WAIT without mem_rvalid: next state DRAIN.
REQ-027 flush in WAIT with simultaneous mem_rvalid: data discarded, next state IDLE, no load.
REQ-028 DRAIN: discard next mem_rvalid, then IDLE; fetch_busy stays high; timeout applies.
REQ-029 flush in DONE: the load pulse already issued stands; clear follows next cycle; state IDLE.
REQ-030 flush and fetch_start together in IDLE: flush wins, fetch_start dropped.

Reset
REQ-031 reset SHALL force state IDLE, counter 0, mem_req=0, mem_addr=0, instr_data=0, ir_control=00, fetch_done=0, fetch_err=0 immediately.
REQ-032 Reset mid-WAIT: a mem_rvalid arriving after reset deasserts SHALL be ignored.

Configuration
REQ-033 Macro INSTR_MISALIGN_CHECK_EN defined: fetch_start with fetch_addr[1:0]!=00 issues no mem_req; next cycle fetch_err=1 and ir_control=10; state remains IDLE.
REQ-034 Macro undefined: no check; mem_addr[1:0] forced to 00.

Structure
REQ-035 Package fetch_pkg SHALL hold the state enum and IR_HOLD/IR_LOAD/IR_CLEAR 2-bit constants, shared with the instruction register's control driver.
REQ-036 One sub-module fetch_timeout_ctr (clear, enable, expired) SHALL implement the timeout counter.

Verification
REQ-037 fetch_addr=0x100, gnt immediate, rvalid next cycle, rdata=0x00500093 -> fetch_done and ir_control=01 at N+3, instr_data=0x00500093.
REQ-038 mem_gnt delayed 3 cycles -> mem_req held 4 cycles, mem_addr=0x100 constant, single load pulse.
REQ-039 flush in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> ir_control=10 once, no fetch_done, instr_data unchanged, IDLE after rvalid.
REQ-040 No rvalid, TIMEOUT_CYCLES=64 -> fetch_err pulse 64 cycles after WAIT entry, ir_control=10, IDLE.
REQ-041 With INSTR_MISALIGN_CHECK_EN, fetch_addr=0x102 -> no mem_req, fetch_err=1 next cycle; without macro -> mem_addr=0x100.
REQ-042 reset asserted in WAIT, rvalid after deassert -> all outputs 0, no fetch_done.
